// File: rtl/card_dealer_datapath.sv
// card_dealer_datapath: baccarat card registers, scores and deal-order checker.
// Ports: slow_clock, resetb (sync, active-high), load_pcard1..3/load_dcard1..3
//   (one-cycle load requests), pcard1..3/dcard1..3 (held card codes 0..13),
//   pscore/dscore (hand scores 0..9), deal_err (sticky), hand_count (hands started).
// Build option: define CARD_LFSR_EN to draw cards from a 7-bit LFSR instead of
//   the 1..13 counter.
module card_dealer_datapath (
   input  logic       slow_clock,
   input  logic       resetb,
   input  logic       load_pcard1,
   input  logic       load_pcard2,
   input  logic       load_pcard3,
   input  logic       load_dcard1,
   input  logic       load_dcard2,
   input  logic       load_dcard3,
   output logic [3:0] pcard1,
   output logic [3:0] pcard2,
   output logic [3:0] pcard3,
   output logic [3:0] dcard1,
   output logic [3:0] dcard2,
   output logic [3:0] dcard3,
   output logic [3:0] pscore,
   output logic [3:0] dscore,
   output logic       deal_err,
   output logic [7:0] hand_count
);

   typedef enum logic [2:0] {
      S_EMPTY, S_P1, S_D1, S_P2, S_D2, S_P3, S_D3
   } state_t;

   // card slots: 0 p1, 1 p2, 2 p3, 3 d1, 4 d2, 5 d3
   logic [5:0][3:0] card_q, card_d;
   logic [5:0]      ld;
   state_t          st_q, st_d;
   logic            err_q, err_d;
   logic [7:0]      hc_q, hc_d;
   logic [3:0]      card_src;

   assign ld = {load_dcard3, load_dcard2, load_dcard1,
                load_pcard3, load_pcard2, load_pcard1};

`ifdef CARD_LFSR_EN
   logic [6:0] lfsr_q, lfsr_d;
   assign lfsr_d   = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
   assign card_src = 4'(lfsr_q % 7'd13) + 4'd1;
`else
   logic [3:0] cnt_q, cnt_d;
   assign cnt_d    = (cnt_q == 4'd13) ? 4'd1 : cnt_q + 4'd1;
   assign card_src = cnt_q;
`endif

   function automatic logic [3:0] val(input logic [3:0] c);
      return (c <= 4'd9) ? c : 4'd0;
   endfunction

   function automatic logic [3:0] score(input logic [3:0] a,
                                        input logic [3:0] b,
                                        input logic [3:0] c);
      logic [4:0] s;
      s = {1'b0, val(a)} + {1'b0, val(b)} + {1'b0, val(c)};
      return 4'(s % 5'd10);
   endfunction

   always_comb begin
      card_d = card_q;
      st_d   = st_q;
      err_d  = err_q;
      hc_d   = hc_q;
      if (ld != 6'd0) begin
         // simultaneous requests are rejected outright, even a new hand
         if (!$onehot(ld)) begin
            err_d = 1'b1;
         end else begin
            unique case (1'b1)
               ld[0]: begin
                  card_d    = '0;
                  card_d[0] = card_src;
                  err_d     = 1'b0;
                  hc_d      = hc_q + 8'd1;
                  st_d      = S_P1;
               end
               ld[3]: if (st_q == S_P1) begin
                  card_d[3] = card_src;
                  st_d      = S_D1;
               end else err_d = 1'b1;
               ld[1]: if (st_q == S_D1) begin
                  card_d[1] = card_src;
                  st_d      = S_P2;
               end else err_d = 1'b1;
               ld[4]: if (st_q == S_P2) begin
                  card_d[4] = card_src;
                  st_d      = S_D2;
               end else err_d = 1'b1;
               ld[2]: if (st_q == S_D2) begin
                  card_d[2] = card_src;
                  st_d      = S_P3;
               end else err_d = 1'b1;
               // dealer may take a third card straight after D2 if player stood
               ld[5]: if (st_q == S_D2 || st_q == S_P3) begin
                  card_d[5] = card_src;
                  st_d      = S_D3;
               end else err_d = 1'b1;
            endcase
         end
      end
   end

   always_ff @(posedge slow_clock) begin
      if (resetb) begin
         card_q <= '0;
         st_q   <= S_EMPTY;
         err_q  <= 1'b0;
         hc_q   <= 8'd0;
`ifdef CARD_LFSR_EN
         lfsr_q <= 7'h01;
`else
         cnt_q  <= 4'd1;
`endif
      end else begin
         card_q <= card_d;
         st_q   <= st_d;
         err_q  <= err_d;
         hc_q   <= hc_d;
`ifdef CARD_LFSR_EN
         lfsr_q <= lfsr_d;
`else
         cnt_q  <= cnt_d;
`endif
      end
   end

   assign pcard1     = card_q[0];
   assign pcard2     = card_q[1];
   assign pcard3     = card_q[2];
   assign dcard1     = card_q[3];
   assign dcard2     = card_q[4];
   assign dcard3     = card_q[5];
   assign pscore     = score(card_q[0], card_q[1], card_q[2]);
   assign dscore     = score(card_q[3], card_q[4], card_q[5]);
   assign deal_err   = err_q;
   assign hand_count = hc_q;

endmodule

// File: tb/tb_card_dealer_datapath.sv
// tb_card_dealer_datapath: directed and randomized checks of card_dealer_datapath
// against a deal-order model built from position-in-deal arithmetic.
module tb_card_dealer_datapath;

   logic       slow_clock = 1'b0;
   logic       resetb = 1'b1;
   logic       load_pcard1 = 1'b0, load_pcard2 = 1'b0, load_pcard3 = 1'b0;
   logic       load_dcard1 = 1'b0, load_dcard2 = 1'b0, load_dcard3 = 1'b0;
   logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
   logic [3:0] pscore, dscore;
   logic       deal_err;
   logic [7:0] hand_count;

   card_dealer_datapath dut (
      .slow_clock (slow_clock),
      .resetb     (resetb),
      .load_pcard1(load_pcard1),
      .load_pcard2(load_pcard2),
      .load_pcard3(load_pcard3),
      .load_dcard1(load_dcard1),
      .load_dcard2(load_dcard2),
      .load_dcard3(load_dcard3),
      .pcard1     (pcard1),
      .pcard2     (pcard2),
      .pcard3     (pcard3),
      .dcard1     (dcard1),
      .dcard2     (dcard2),
      .dcard3     (dcard3),
      .pscore     (pscore),
      .dscore     (dscore),
      .deal_err   (deal_err),
      .hand_count (hand_count)
   );

   always #5 slow_clock = ~slow_clock;

   // load vectors, bit order {d3,d2,d1,p3,p2,p1}
   localparam logic [5:0] NONE = 6'b000000;
   localparam logic [5:0] P1 = 6'b000001;
   localparam logic [5:0] P2 = 6'b000010;
   localparam logic [5:0] P3 = 6'b000100;
   localparam logic [5:0] D1 = 6'b001000;
   localparam logic [5:0] D2 = 6'b010000;
   localparam logic [5:0] D3 = 6'b100000;

   int tests = 0;
   int fails = 0;

   // model: cards per slot, position reached in the deal order
   int m_card[6];
   int ord[6];
   int m_pos, m_hc, m_err, m_src, m_lfsr;

   function automatic int cval(input int c);
      return (c >= 1 && c <= 9) ? c : 0;
   endfunction

   function automatic int cur_src();
`ifdef CARD_LFSR_EN
      return (m_lfsr % 13) + 1;
`else
      return m_src;
`endif
   endfunction

   task automatic check(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".pcard1"}, int'(pcard1), m_card[0]);
      check({tag, ".pcard2"}, int'(pcard2), m_card[1]);
      check({tag, ".pcard3"}, int'(pcard3), m_card[2]);
      check({tag, ".dcard1"}, int'(dcard1), m_card[3]);
      check({tag, ".dcard2"}, int'(dcard2), m_card[4]);
      check({tag, ".dcard3"}, int'(dcard3), m_card[5]);
      check({tag, ".pscore"}, int'(pscore),
            (cval(m_card[0]) + cval(m_card[1]) + cval(m_card[2])) % 10);
      check({tag, ".dscore"}, int'(dscore),
            (cval(m_card[3]) + cval(m_card[4]) + cval(m_card[5])) % 10);
      check({tag, ".deal_err"}, int'(deal_err), m_err);
      check({tag, ".hand_count"}, int'(hand_count), m_hc);
   endtask

   task automatic model_edge(input logic [5:0] ld, input logic rst);
      int n;
      int t;
      int src;
      src = cur_src();
      if (rst) begin
         foreach (m_card[i]) m_card[i] = 0;
         m_pos  = 0;
         m_hc   = 0;
         m_err  = 0;
         m_src  = 1;
         m_lfsr = 1;
      end else begin
         n = $countones(ld);
         t = 0;
         for (int i = 0; i < 6; i++) if (ld[i]) t = i;
         if (n > 1) begin
            m_err = 1;
         end else if (n == 1) begin
            if (t == 0) begin
               foreach (m_card[i]) m_card[i] = 0;
               m_card[0] = src;
               m_err = 0;
               m_hc  = (m_hc + 1) % 256;
               m_pos = 1;
            end else if (ord[t] == m_pos + 1 || (t == 5 && m_pos == 4)) begin
               m_card[t] = src;
               m_pos = ord[t];
            end else begin
               m_err = 1;
            end
         end
         m_src  = (m_src % 13) + 1;
         m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 6) ^ (m_lfsr >> 5)) & 1)) & 127;
      end
   endtask

   task automatic step(input string tag, input logic [5:0] ld, input logic rst);
      {load_dcard3, load_dcard2, load_dcard1,
       load_pcard3, load_pcard2, load_pcard1} = ld;
      resetb = rst;
      @(posedge slow_clock);
      model_edge(ld, rst);
      @(negedge slow_clock);
      {load_dcard3, load_dcard2, load_dcard1,
       load_pcard3, load_pcard2, load_pcard1} = NONE;
      resetb = 1'b0;
      check_all(tag);
   endtask

   initial begin
      int k;
      int r;
      logic [5:0] ld;
      ord = '{1, 3, 5, 2, 4, 6};
      @(negedge slow_clock);

      step("reset", NONE, 1'b1);

      step("idle", NONE, 1'b0);
      step("p1", P1, 1'b0);
      step("d1", D1, 1'b0);
      step("p2", P2, 1'b0);
      step("d2", D2, 1'b0);
`ifndef CARD_LFSR_EN
      check("basic.pcard1", int'(pcard1), 2);
      check("basic.dcard1", int'(dcard1), 3);
      check("basic.pcard2", int'(pcard2), 4);
      check("basic.dcard2", int'(dcard2), 5);
      check("basic.pscore", int'(pscore), 6);
      check("basic.dscore", int'(dscore), 8);
      check("basic.deal_err", int'(deal_err), 0);
      check("basic.hand_count", int'(hand_count), 1);
`endif

      step("p3", P3, 1'b0);
      step("d3", D3, 1'b0);
`ifndef CARD_LFSR_EN
      check("three.pcard3", int'(pcard3), 6);
      check("three.dcard3", int'(dcard3), 7);
      check("three.pscore", int'(pscore), 2);
      check("three.dscore", int'(dscore), 5);
`endif
      step("after_d3_p2", P2, 1'b0);
      check("after_d3.err", int'(deal_err), 1);

      k = 0;
      while (cur_src() != 13 && k < 200) begin
         step("wait13", NONE, 1'b0);
         k++;
      end
      step("face_p1", P1, 1'b0);
      check("face.pcard1", int'(pcard1), 13);
      step("face_d1", D1, 1'b0);
`ifndef CARD_LFSR_EN
      check("wrap.dcard1", int'(dcard1), 1);
`endif
      k = 0;
      while (cur_src() != 9 && k < 200) begin
         step("wait9", NONE, 1'b0);
         k++;
      end
      step("face_p2", P2, 1'b0);
      check("face.pscore", int'(pscore), 9);

      step("ord_p1", P1, 1'b0);
      step("ord_d2", D2, 1'b0);
      check("order.err", int'(deal_err), 1);
      step("ord_newhand", P1, 1'b0);
      check("order.cleared", int'(deal_err), 0);
      check("order.dcard1", int'(dcard1), 0);

      step("sim_d1", D1, 1'b0);
      step("sim_p1d1", P1 | D1, 1'b0);
      check("simul.err", int'(deal_err), 1);
      step("rst_p1", P1, 1'b1);
      check("rstprio.hand_count", int'(hand_count), 0);
      check("rstprio.pcard1", int'(pcard1), 0);

      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 99);
         if (r < 3) begin
            ld = 6'($urandom_range(0, 63));
            step("rnd_rst", ld, 1'b1);
         end else begin
            if (r < 10) ld = 6'($urandom_range(0, 63));
            else if (r < 25) ld = NONE;
            else if (r < 35) ld = P1;
            else if (r < 75) begin
               ld = P1;
               for (int t = 0; t < 6; t++)
                  if (ord[t] == m_pos + 1) ld = 6'(1 << t);
               if (m_pos == 4 && r < 45) ld = D3;
            end else ld = 6'(1 << $urandom_range(0, 5));
            step("rnd", ld, 1'b0);
         end
      end

      for (int i = 0; i < 1000; i++) begin
         step("sweep", P1, 1'b0);
         check("sweep.range", int'(pcard1 >= 4'd1 && pcard1 <= 4'd13), 1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/card_dealer_datapath.md
CARD_DEALER_DATAPATH -- requirements
Module: card_dealer_datapath

Interface
REQ-001 The block SHALL have port slow_clock, input, 1, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port resetb, input, 1, synchronous active-high reset, sampled on the slow_clock rising edge.
REQ-003 The block SHALL have ports load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2 and load_dcard3, each an input of width 1, each a one-cycle load request from the game state machine.
REQ-004 The block SHALL have ports pcard1, pcard2, pcard3, dcard1, dcard2 and dcard3, each an output of width 4, each a held card code: 0 = no card, 1..13 = A..K.
REQ-005 The block SHALL have ports pscore and dscore, each an output of width 4, each a hand score in the range 0..9.
REQ-006 The block SHALL have port deal_err, output, 1, a sticky protocol-error flag.
REQ-007 The block SHALL have port hand_count, output, 8, the number of hands started.

Function
REQ-008 The block SHALL contain a card source card_src (4 bits, values 1..13) that advances every cycle, including cycles with no load.
REQ-009 A granted load SHALL write the card_src value present at that edge into the target register; the card is visible on the output the cycle after the load.
REQ-010 Card value SHALL be: codes 1..9 are worth their code; codes 0 and 10..13 are worth 0.
REQ-011 pscore SHALL be (value(pcard1)+value(pcard2)+value(pcard3)) mod 10, combinational from the card registers with zero added latency; dscore SHALL be computed the same way from the dcards.
REQ-012 A deal-order FSM SHALL track states EMPTY, P1, D1, P2, D2, P3 and D3, each named for the last card granted.
REQ-013 The legal next loads SHALL be: EMPTY->P1, P1->D1, D1->P2, P2->D2, D2->P3, D2->D3 (player stood), P3->D3; a load_pcard1 from any state SHALL be legal.
REQ-014 A load_pcard1 SHALL start a new hand: it loads pcard1, clears the other five card registers to 0, clears deal_err, increments hand_count (wrapping 255->0), and moves the FSM to P1.
REQ-015 An illegal single load SHALL leave all card registers and the FSM state unchanged and SHALL set deal_err.
REQ-016 Two or more load inputs high in the same cycle SHALL cause no register update and no FSM change, and SHALL set deal_err; this rule SHALL apply even when load_pcard1 is one of them.
REQ-017 Cycles with no load SHALL hold all registers; the card source SHALL still advance.
REQ-018 States D3 and P3 SHALL accept only the loads listed in REQ-013; any other load in those states SHALL be an error.

Reset
REQ-019 When resetb=1 at an edge, the block SHALL clear all card registers to 0, pscore and dscore to 0, deal_err to 0 and hand_count to 0, set the FSM to EMPTY, and set card_src to 1.
REQ-020 Reset SHALL take priority over any simultaneous load.
REQ-021 A reset mid-hand SHALL discard the hand; the first cycle after reset SHALL behave as EMPTY.

Configuration
REQ-022 With CARD_LFSR_EN defined, card_src SHALL be (L mod 13)+1.
- L is a 7-bit Fibonacci LFSR with taps x^7+x^6+1, reset seed 7'h01, shifting every cycle.
REQ-023 With CARD_LFSR_EN undefined, card_src SHALL be a counter.
- It counts 1,2,...,13,1,... and advances by one every cycle.

Verification
REQ-024 The bench SHALL cover a basic deal with the counter source: reset; one idle cycle; pulse loads P1, D1, P2 and D2 on consecutive cycles. Required result: pcard1=2, dcard1=3, pcard2=4, dcard2=5, pscore=6, dscore=8, deal_err=0, hand_count=1.
REQ-025 The bench SHALL cover face cards and wrap: force the deal so that pcard1=13 and pcard2=9. Required result: pscore=9; card_src steps 13->1 on the following cycle.
REQ-026 The bench SHALL cover the three-card path: after D2, pulse P3 then D3. Required result: both registers loaded, and each score equals the sum of all three card values mod 10.
REQ-027 The bench SHALL cover an order error: pulse load_dcard2 while the FSM is in P1. Required result: deal_err=1 and all cards unchanged; a following load_pcard1 clears deal_err, zeroes the five other cards, and sets hand_count=2.
REQ-028 The bench SHALL cover simultaneous loads and reset priority. Stimulus 1: load_pcard1 and load_dcard1 high together. Required result: no update and deal_err=1. Stimulus 2: resetb high together with load_pcard1. Required result: all outputs 0 and hand_count=0.
REQ-029 The bench SHALL cover the LFSR build: with CARD_LFSR_EN defined, over 1000 cycles every card_src value lies in 1..13 and none is 0.
